// File: rtl/truth_table_sweeper_if.sv
// rtl/truth_table_sweeper_if.sv - stimulus/response and result bundle for truth_table_sweeper (care_mask present only with SWEEP_MASK_EN)
interface truth_table_sweeper_if #(
   parameter int IN_W  = 3,
   parameter int OUT_W = 2
);
   logic              start;
   logic [IN_W-1:0]   vec_out;
   logic [OUT_W-1:0]  dut_out;
   logic [OUT_W-1:0]  exp_out;
`ifdef SWEEP_MASK_EN
   logic [OUT_W-1:0]  care_mask;
`endif
   logic              busy;
   logic              done;
   logic              pass;
   logic [IN_W:0]     err_count;
   logic [IN_W:0]     zero_count;
   logic [IN_W-1:0]   first_fail_vec;
   logic              first_fail_valid;

   // Sweeper side: drives the vector and results, observes DUT and golden model
   modport master (
      input  start, dut_out, exp_out,
`ifdef SWEEP_MASK_EN
      input  care_mask,
`endif
      output vec_out, busy, done, pass, err_count, zero_count,
             first_fail_vec, first_fail_valid
   );

   // Environment side: DUT, golden model and controller
   modport slave (
      output start, dut_out, exp_out,
`ifdef SWEEP_MASK_EN
      output care_mask,
`endif
      input  vec_out, busy, done, pass, err_count, zero_count,
             first_fail_vec, first_fail_valid
   );
endinterface

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - exhaustive input sweeper comparing a DUT against a golden model (optional SWEEP_MASK_EN)
module truth_table_sweeper #(
   parameter int IN_W   = 3,
   parameter int OUT_W  = 2,
   parameter int SETTLE = 20
) (
   input  logic                   clk,
   input  logic                   rst,
   truth_table_sweeper_if.master  bus
);

   localparam int CW = IN_W + 1;
   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETTLE = 2'd1;
   localparam logic [1:0] S_SAMPLE = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [1:0]      state_q, state_d;
   logic [IN_W-1:0] vec_q, vec_d;
   logic [SW-1:0]   settle_q, settle_d;
   logic [CW-1:0]   err_q, err_d;
   logic [CW-1:0]   zero_q, zero_d;
   logic [IN_W-1:0] ff_vec_q, ff_vec_d;
   logic            ff_valid_q, ff_valid_d;
   logic            pass_q, pass_d;

   logic [OUT_W-1:0] diff;
   logic             mismatch;

   // Bits that disagree with the golden model, restricted to cared-for bits when masking
   always_comb begin
      diff = bus.dut_out ^ bus.exp_out;
`ifdef SWEEP_MASK_EN
      diff = diff & bus.care_mask;
`endif
      mismatch = |diff;
   end

   // Sweep sequencing, result accumulation and first-fail capture
   always_comb begin
      state_d    = state_q;
      vec_d      = vec_q;
      settle_d   = settle_q;
      err_d      = err_q;
      zero_d     = zero_q;
      ff_vec_d   = ff_vec_q;
      ff_valid_d = ff_valid_q;
      pass_d     = pass_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            // A restart from DONE behaves exactly like a start from IDLE
            if (bus.start) begin
               state_d    = S_SETTLE;
               vec_d      = '0;
               settle_d   = SETTLE_LOAD;
               err_d      = '0;
               zero_d     = '0;
               ff_vec_d   = '0;
               ff_valid_d = 1'b0;
               pass_d     = 1'b0;
            end
         end
         S_SETTLE: begin
            if (settle_q == '0) begin
               state_d = S_SAMPLE;
            end else begin
               settle_d = settle_q - SW'(1);
            end
         end
         S_SAMPLE: begin
            if (mismatch) begin
               err_d = err_q + CW'(1);
               if (!ff_valid_q) begin
                  ff_vec_d   = vec_q;
                  ff_valid_d = 1'b1;
               end
            end
            if (bus.dut_out == '0) begin
               zero_d = zero_q + CW'(1);
            end
            // Terminal check precedes the increment so the vector never wraps
            if (&vec_q) begin
               state_d = S_DONE;
               pass_d  = (err_d == '0);
            end else begin
               vec_d    = vec_q + IN_W'(1);
               settle_d = SETTLE_LOAD;
               state_d  = S_SETTLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; reset clears every result so nothing partial survives
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         vec_q      <= '0;
         settle_q   <= '0;
         err_q      <= '0;
         zero_q     <= '0;
         ff_vec_q   <= '0;
         ff_valid_q <= 1'b0;
         pass_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         vec_q      <= vec_d;
         settle_q   <= settle_d;
         err_q      <= err_d;
         zero_q     <= zero_d;
         ff_vec_q   <= ff_vec_d;
         ff_valid_q <= ff_valid_d;
         pass_q     <= pass_d;
      end
   end

   assign bus.vec_out          = vec_q;
   assign bus.busy             = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
   assign bus.done             = (state_q == S_DONE);
   assign bus.pass             = pass_q;
   assign bus.err_count        = err_q;
   assign bus.zero_count       = zero_q;
   assign bus.first_fail_vec   = ff_vec_q;
   assign bus.first_fail_valid = ff_valid_q;

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Synthesizable, parametrised successor to our exhaustive combinational lab benches. Drives every input combination of an IN_W-bit combinational DUT, waits a programmable settle interval, then compares DUT outputs against a golden-model value. Counts mismatches and all-zero-output vectors, and latches the first failing vector. Sits between a golden model and the DUT, and can run on the FPGA board as well as in simulation.

## Interface
- IN_W, 3: DUT input width. Sweep covers 2^IN_W vectors. Legal range 1..16.
- OUT_W, 2: DUT output width. Must be at least 1.
- SETTLE, 20: clock cycles a vector is held before sampling. Must be at least 1.

- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a sweep.
- vec_out  out  IN_W  stimulus vector to the DUT and the golden model.
- dut_out  in  OUT_W  DUT response.
- exp_out  in  OUT_W  golden-model response for the current vec_out.
- busy  out  1  high while a sweep is in progress.
- done  out  1  high from sweep completion until the next accepted start or rst.
- pass  out  1  equals done && err_count==0, registered.
- err_count  out  IN_W+1  number of mismatching vectors.
- zero_count  out  IN_W+1  number of vectors where dut_out == 0.
- first_fail_vec  out  IN_W  first mismatching vector.
- first_fail_valid  out  1  high once first_fail_vec has been captured.

## Operation
- Reset value of every output: 0, including vec_out.
- The FSM has four states: IDLE, SETTLE, SAMPLE and DONE.
- IDLE
  - start=1 loads vec_out=0, clears both counters and the first-fail capture, loads settle_cnt=SETTLE-1, and moves to SETTLE.
- SETTLE
  - Decrements settle_cnt each cycle.
  - When settle_cnt==0, moves to SAMPLE.
- SAMPLE (one cycle)
  - A mismatch is dut_out != exp_out. On a mismatch, err_count increments.
  - On the first mismatch of a sweep, first_fail_vec captures vec_out and first_fail_valid is set.
  - If dut_out==0, zero_count increments.
  - If vec_out is all ones, the FSM moves to DONE and vec_out is held at its value.
  - Otherwise vec_out increments, settle_cnt reloads SETTLE-1, and the FSM returns to SETTLE.
- DONE
  - done=1, pass is valid, and results are held.
  - start=1 restarts exactly as from IDLE, on the same edge.
- busy=1 in SETTLE and SAMPLE only. A start pulse while busy is ignored.
- Counter widths: IN_W+1 bits, so the maximum count of 2^IN_W is representable without wrap.
- The vector counter never wraps: the terminal check happens before the increment.

## Timing
- Each vector occupies SETTLE+1 cycles: SETTLE cycles in SETTLE plus 1 cycle in SAMPLE.
- A start accepted at edge t0 presents vec_out=0 after t0.
- Vector k is sampled at edge t0 + (k+1)(SETTLE+1).
- done rises on edge t0 + 2^IN_W·(SETTLE+1), the edge after the final SAMPLE. pass updates on that same edge.
- err_count, zero_count and first_fail_* update on the SAMPLE edge. They are visible the following cycle.
- rst has priority over start in the same cycle.
- rst in mid-sweep returns to IDLE with all outputs at their reset values on the next edge. No partial results are retained.
- A start in the same cycle that DONE is entered is ignored. It is accepted from the next cycle.

## Configuration
- SWEEP_MASK_EN defined:
  - Adds input care_mask [OUT_W-1:0].
  - The mismatch test becomes ((dut_out ^ exp_out) & care_mask) != 0.
  - zero_count is unaffected by the mask.
  - care_mask is sampled in SAMPLE and may change between sweeps.
- SWEEP_MASK_EN undefined:
  - No care_mask port exists.
  - All OUT_W bits are compared.

## Test plan
All scenarios use IN_W=3, OUT_W=2, SETTLE=4 and exp_out={vec[2]&vec[1], vec[1]|vec[0]}.

- Matching DUT: dut_out=exp_out, start pulsed at t0.
  - done rises exactly 40 cycles after t0.
  - pass=1, err_count=0, zero_count=2, first_fail_valid=0.
- Stuck-at-zero DUT: dut_out=00.
  - err_count=6, zero_count=8, pass=0.
  - first_fail_vec=3'b001, first_fail_valid=1.
- Mid-sweep reset: rst asserted while vec_out=3'b101.
  - All outputs are 0 the next cycle and the FSM is in IDLE.
  - A following start completes a clean sweep (pass=1).
- Start handling: start re-pulsed while busy does not alter the vec_out sequence or completion time.
  - start pulsed in DONE clears done and the counters, and restarts at vec_out=0.
- With SWEEP_MASK_EN and care_mask=2'b01: dut_out={~exp[1], exp[0]}.
  - err_count=0 and pass=1.
- With SWEEP_MASK_EN and care_mask=2'b11: same dut_out as above.
  - err_count=8 and first_fail_vec=3'b000.
